// File: rtl/fhn_pkg.sv
// Shared definitions for the FHN neuron core output-side blocks.
package fhn_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned FRC_BITS = 12;
  localparam int unsigned TS_W     = 32;

  // Q4.12 constants
  localparam logic signed [DATA_W-1:0] ONE  = 16'sd4096;
  localparam logic signed [DATA_W-1:0] HALF = 16'sd2048;

  // Event record as it appears on the event bus, MSB first: {ts, peak, width}
  typedef struct packed {
    logic [TS_W-1:0]          ts;
    logic signed [DATA_W-1:0] peak;
    logic [DATA_W-1:0]        width;
  } event_t;

  typedef enum logic [0:0] {
    StBelow,
    StAbove
  } state_e;

endpackage

// File: rtl/fhn_spike_monitor_if.sv
// Valid/ready event stream carrying one spike record per transfer.
interface fhn_spike_monitor_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TS_W   = 32
);

  logic                     ev_valid;
  logic                     ev_ready;
  logic [TS_W-1:0]          ev_ts;
  logic signed [DATA_W-1:0] ev_peak;
  logic [DATA_W-1:0]        ev_width;

  modport master (
    output ev_valid,
    output ev_ts,
    output ev_peak,
    output ev_width,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_ts,
    input  ev_peak,
    input  ev_width,
    output ev_ready
  );

endinterface

// File: rtl/fhn_event_fifo.sv
// First-word-fall-through synchronous FIFO. A push on a full FIFO is accepted
// only when a pop happens in the same cycle (the head slot is reused).
// DEPTH must be a power of two, at least 2.
module fhn_event_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  // Storage and pointers; flush empties without clearing storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fhn_spike_monitor.sv
// Spike extractor for the FHN core membrane voltage: hysteresis detection on
// the registered sample, minimum-width qualification, and buffered events.
module fhn_spike_monitor #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned TS_W       = 32,
  parameter int unsigned MIN_W      = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] v,
  input  logic signed [DATA_W-1:0] th_hi,
  input  logic signed [DATA_W-1:0] th_lo,
  fhn_spike_monitor_if.master      ev,
  output logic [15:0]              spike_count,
  output logic                     overflow
);

  import fhn_pkg::*;

  localparam int unsigned      EV_W      = TS_W + 2 * DATA_W;
  localparam logic [DATA_W-1:0] WIDTH_MAX = '1;
  localparam logic [DATA_W-1:0] MIN_W_L   = DATA_W'(MIN_W);

  logic signed [DATA_W-1:0] v_q;
  logic signed [DATA_W-1:0] lo_eff;
  logic signed [DATA_W-1:0] peak_q, peak_d;
  logic [DATA_W-1:0]        width_q, width_d;
  logic [TS_W-1:0]          ts_cnt_q;
  logic [TS_W-1:0]          cap_ts_q, cap_ts_d;
  state_e                   state_q, state_d;
  logic                     qualify;
  logic                     push;
  logic                     pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [EV_W-1:0]          ev_wdata;
  logic [EV_W-1:0]          ev_rdata;

  // A th_lo above th_hi collapses to no hysteresis rather than a stuck FSM
  assign lo_eff = (th_lo < th_hi) ? th_lo : th_hi;

  // Sample register; clr does not touch it so detection restarts on live data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
    end else if (en) begin
      v_q <= v;
    end
  end

  // Time base: counts enabled cycles since reset or clr, wraps silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt_q <= '0;
    end else if (clr) begin
      ts_cnt_q <= '0;
    end else if (en) begin
      ts_cnt_q <= ts_cnt_q + TS_W'(1);
    end
  end

  // Detection FSM next-state, capture and qualification
  always_comb begin
    state_d  = state_q;
    cap_ts_d = cap_ts_q;
    peak_d   = peak_q;
    width_d  = width_q;
    qualify  = 1'b0;
    unique case (state_q)
      StBelow: begin
        if (v_q >= th_hi) begin
          state_d  = StAbove;
          cap_ts_d = ts_cnt_q;
          peak_d   = v_q;
          width_d  = DATA_W'(1);
        end
      end
      StAbove: begin
        if (v_q < lo_eff) begin
          state_d = StBelow;
          qualify = (width_q >= MIN_W_L);
        end else begin
          if (v_q > peak_q) begin
            peak_d = v_q;
          end
          if (width_q != WIDTH_MAX) begin
            width_d = width_q + DATA_W'(1);
          end
        end
      end
      default: state_d = StBelow;
    endcase
  end

  // Detection FSM state; frozen while en is low, abandoned on clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StBelow;
      cap_ts_q <= '0;
      peak_q   <= '0;
      width_q  <= '0;
    end else if (clr) begin
      state_q <= StBelow;
    end else if (en) begin
      state_q  <= state_d;
      cap_ts_q <= cap_ts_d;
      peak_q   <= peak_d;
      width_q  <= width_d;
    end
  end

  assign push     = en && !clr && qualify;
  assign pop      = ev.ev_ready && !fifo_empty;
  assign ev_wdata = {cap_ts_q, peak_q, width_q};

  // Statistics; a drop happens only when full and nothing leaves this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_count <= '0;
      overflow    <= 1'b0;
    end else if (clr) begin
      spike_count <= '0;
      overflow    <= 1'b0;
    end else if (push) begin
      if (spike_count != 16'hffff) begin
        spike_count <= spike_count + 16'd1;
      end
      if (fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  fhn_event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (clr),
    .push  (push),
    .wdata (ev_wdata),
    .pop   (pop),
    .rdata (ev_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ev.ev_valid = !fifo_empty;
  assign {ev.ev_ts, ev.ev_peak, ev.ev_width} = ev_rdata;

endmodule

// File: tb/tb_fhn_spike_monitor.sv
// Directed bench for fhn_spike_monitor: reset, single spike, glitch rejection,
// hysteresis, overflow, push-on-full with pop, enable freeze, th_lo clamping.
module tb_fhn_spike_monitor;

  localparam logic signed [15:0] VH = 16'sd6144;
  localparam logic signed [15:0] VL = -16'sd4096;

  logic               clk;
  logic               rst;
  logic               en;
  logic               clr;
  logic signed [15:0] v;
  logic signed [15:0] th_hi;
  logic signed [15:0] th_lo;
  logic [15:0]        spike_count;
  logic               overflow;

  int          checks;
  int          errors;
  logic [31:0] ts_model;
  logic [31:0] ts_arr [9];
  logic [31:0] t_exp;
  logic [31:0] t9;

  fhn_spike_monitor_if #(.DATA_W(16), .TS_W(32)) ev_if ();

  fhn_spike_monitor #(
    .DATA_W     (16),
    .TS_W       (32),
    .MIN_W      (4),
    .FIFO_DEPTH (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .clr         (clr),
    .v           (v),
    .th_hi       (th_hi),
    .th_lo       (th_lo),
    .ev          (ev_if),
    .spike_count (spike_count),
    .overflow    (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; the bench's own time base counts enabled cycles since reset/clr
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (clr) ts_model = '0;
      else if (en) ts_model = ts_model + 32'd1;
    end
    #1;
  endtask

  task automatic cyc(input logic signed [15:0] vv);
    v = vv;
    tick();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic pop_one();
    ev_if.ev_ready = 1'b1;
    tick();
    ev_if.ev_ready = 1'b0;
  endtask

  // n high samples then six low ones; event (if any) is visible on return
  task automatic pulse(input int n, output logic [31:0] ts_e);
    ts_e = ts_model + 32'd1;
    repeat (n) cyc(VH);
    repeat (6) cyc(VL);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    ts_model       = '0;
    rst            = 1'b1;
    en             = 1'b1;
    clr            = 1'b0;
    v              = VH;
    th_hi          = 16'sd2048;
    th_lo          = 16'sd0;
    ev_if.ev_ready = 1'b1;

    // Reset holds everything at zero even with a high v
    repeat (3) begin
      tick();
      check("rst_valid", 64'(ev_if.ev_valid), 64'd0);
      check("rst_count", 64'(spike_count), 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);
    end
    v   = VL;
    en  = 1'b0;
    rst = 1'b0;
    tick();
    check("post_rst_valid", 64'(ev_if.ev_valid), 64'd0);
    check("post_rst_ts", 64'(ev_if.ev_ts), 64'd0);
    check("post_rst_peak", 64'(ev_if.ev_peak), 64'd0);
    check("post_rst_width", 64'(ev_if.ev_width), 64'd0);
    check("post_rst_count", 64'(spike_count), 64'd0);
    check("post_rst_ovf", 64'(overflow), 64'd0);

    // Single spike: cycles counted from the first enabled cycle
    ev_if.ev_ready = 1'b0;
    en             = 1'b1;
    for (int c = 0; c < 32; c++) begin
      if (c < 10) v = VL;
      else if (c < 30) v = (c == 15) ? 16'sd7000 : VH;
      else v = VL;
      if (c == 31) check("spk_latency", 64'(ev_if.ev_valid), 64'd0);
      tick();
    end
    v = VL;
    check("spk_valid", 64'(ev_if.ev_valid), 64'd1);
    check("spk_ts", 64'(ev_if.ev_ts), 64'd11);
    check("spk_peak", 64'(ev_if.ev_peak), 64'd7000);
    check("spk_width", 64'(ev_if.ev_width), 64'd20);
    check("spk_count", 64'(spike_count), 64'd1);
    pop_one();
    check("spk_drained", 64'(ev_if.ev_valid), 64'd0);

    // Glitch of 2 cycles is rejected; 4 cycles is exactly enough
    pulse(2, t_exp);
    check("glitch_valid", 64'(ev_if.ev_valid), 64'd0);
    check("glitch_count", 64'(spike_count), 64'd1);
    pulse(4, t_exp);
    check("minw_valid", 64'(ev_if.ev_valid), 64'd1);
    check("minw_width", 64'(ev_if.ev_width), 64'd4);
    check("minw_ts", 64'(ev_if.ev_ts), 64'(t_exp));
    check("minw_count", 64'(spike_count), 64'd2);
    pop_one();

    // Hysteresis: dips to 1000 stay above th_lo, so one long spike
    t_exp = ts_model + 32'd1;
    cyc(16'sd3000);
    for (int i = 0; i < 50; i++) cyc((i % 2 == 1) ? 16'sd3000 : 16'sd1000);
    repeat (6) cyc(-16'sd100);
    check("hyst_valid", 64'(ev_if.ev_valid), 64'd1);
    check("hyst_ts", 64'(ev_if.ev_ts), 64'(t_exp));
    check("hyst_peak", 64'(ev_if.ev_peak), 64'd3000);
    check("hyst_width", 64'(ev_if.ev_width), 64'd51);
    check("hyst_count", 64'(spike_count), 64'd3);
    pop_one();
    check("hyst_single", 64'(ev_if.ev_valid), 64'd0);

    // Overflow: nine spikes into an eight-deep buffer with no consumer
    do_clr();
    check("clr_count", 64'(spike_count), 64'd0);
    for (int i = 0; i < 9; i++) pulse(4, ts_arr[i]);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_count", 64'(spike_count), 64'd9);
    check("ovf_valid", 64'(ev_if.ev_valid), 64'd1);
    ev_if.ev_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", 64'(ev_if.ev_valid), 64'd1);
      check("drain_ts", 64'(ev_if.ev_ts), 64'(ts_arr[i]));
      check("drain_peak", 64'(ev_if.ev_peak), 64'd6144);
      tick();
    end
    ev_if.ev_ready = 1'b0;
    check("drain_empty", 64'(ev_if.ev_valid), 64'd0);
    do_clr();
    check("clr_ovf", 64'(overflow), 64'd0);
    check("clr_count2", 64'(spike_count), 64'd0);
    check("clr_valid", 64'(ev_if.ev_valid), 64'd0);

    // Push while full with a pop in the same cycle keeps the new event
    for (int i = 0; i < 8; i++) pulse(4, ts_arr[i]);
    check("full_ovf", 64'(overflow), 64'd0);
    check("full_count", 64'(spike_count), 64'd8);
    t9 = ts_model + 32'd1;
    repeat (4) cyc(VH);
    cyc(VL);
    ev_if.ev_ready = 1'b1;
    cyc(VL);
    ev_if.ev_ready = 1'b0;
    repeat (3) cyc(VL);
    check("pp_ovf", 64'(overflow), 64'd0);
    check("pp_count", 64'(spike_count), 64'd9);
    ev_if.ev_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("pp_valid", 64'(ev_if.ev_valid), 64'd1);
      check("pp_ts", 64'(ev_if.ev_ts), 64'((i < 7) ? ts_arr[i+1] : t9));
      tick();
    end
    ev_if.ev_ready = 1'b0;
    check("pp_empty", 64'(ev_if.ev_valid), 64'd0);

    // en low mid-spike freezes width and time base
    do_clr();
    t_exp = ts_model + 32'd1;
    repeat (3) cyc(VH);
    en = 1'b0;
    repeat (5) cyc(VH);
    en = 1'b1;
    repeat (3) cyc(VH);
    repeat (6) cyc(VL);
    check("frz_valid", 64'(ev_if.ev_valid), 64'd1);
    check("frz_width", 64'(ev_if.ev_width), 64'd6);
    check("frz_ts", 64'(ev_if.ev_ts), 64'(t_exp));
    check("frz_count", 64'(spike_count), 64'd1);
    pop_one();

    // th_lo above th_hi falls back to th_hi as the falling threshold
    th_lo = 16'sd5000;
    repeat (4) cyc(16'sd3000);
    repeat (6) cyc(16'sd1000);
    check("lo_eff_valid", 64'(ev_if.ev_valid), 64'd1);
    check("lo_eff_width", 64'(ev_if.ev_width), 64'd4);
    check("lo_eff_count", 64'(spike_count), 64'd2);
    pop_one();
    th_lo = 16'sd0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
